// File: rtl/ranc_axon_pkg.sv
// Shared types and defaults for the axon spike decoder: packet/bitmap widths
// and the bank-select encoding used by the double-buffered bitmap.
package ranc_axon_pkg;

  localparam int AXON_W_DEF    = 8;
  localparam int NUM_AXONS_DEF = 256;

  typedef logic [AXON_W_DEF-1:0]    axon_idx_t;
  typedef logic [NUM_AXONS_DEF-1:0] axon_map_t;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_sel_e;

  function automatic bank_sel_e other_bank(input bank_sel_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/axon_bank.sv
// One axon spike bitmap: sets a single bit per cycle and clears the whole
// vector synchronously; clear wins over set.
module axon_bank
  import ranc_axon_pkg::*;
#(
  parameter int NUM_AXONS = NUM_AXONS_DEF,
  parameter int AXON_W    = AXON_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 set_en,
  input  logic [AXON_W-1:0]    set_idx,
  output logic [NUM_AXONS-1:0] bits
);

  logic [NUM_AXONS-1:0] bits_q;
  logic [NUM_AXONS-1:0] bits_d;

  always_comb begin
    // NOTE: default assignment first, so no path leaves bits_d unassigned and no latch is inferred.
    bits_d = bits_q;
    if (clr) begin
      bits_d = '0;
    end else if (set_en) begin
      bits_d[set_idx] = 1'b1;
    end
  end

  // NOTE: the bitmap is reset along with the control state so no stale spikes survive rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign bits = bits_q;

endmodule

// File: rtl/axon_spike_decoder.sv
// Pops axon-index packets from the spike FIFO and accumulates them into a
// double-buffered per-tick bitmap plus a saturating spike count.
module axon_spike_decoder
  import ranc_axon_pkg::*;
#(
  parameter int AXON_W    = AXON_W_DEF,
  parameter int NUM_AXONS = NUM_AXONS_DEF,
  parameter int CNT_W     = AXON_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [AXON_W-1:0]    fifo_data,
  output logic                 fifo_r_en,
  input  logic                 tick,
  output logic [NUM_AXONS-1:0] axon_spikes,
  output logic                 spikes_valid,
  output logic [CNT_W-1:0]     spike_count,
  output logic                 drop_err
);

  // One extra bit so NUM_AXONS == 2**AXON_W still compares correctly.
  localparam logic [AXON_W:0]  NUM_AXONS_EXT = (AXON_W + 1)'(NUM_AXONS);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  logic                 rd_pend_q, rd_pend_d;
  bank_sel_e            bank_sel_q, bank_sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_AXONS-1:0] axon_spikes_q, axon_spikes_d;
  logic [CNT_W-1:0]     spike_count_q, spike_count_d;
  logic                 spikes_valid_q, spikes_valid_d;
  logic                 drop_err_q, drop_err_d;

  logic                 in_range;
  logic                 capture;
  logic [CNT_W-1:0]     cnt_now;
  logic [NUM_AXONS-1:0] acc_now;
  logic [NUM_AXONS-1:0] bank0_bits, bank1_bits;
  logic                 bank0_set, bank1_set;
  logic                 bank0_clr, bank1_clr;

  assign fifo_r_en = !fifo_empty && !rst;

  always_comb begin
    in_range = ({1'b0, fifo_data} < NUM_AXONS_EXT);
    capture  = rd_pend_q && in_range;

    // Accumulating bank as it will look after this cycle's capture.
    acc_now = (bank_sel_q == BANK_0) ? bank0_bits : bank1_bits;
    if (capture) begin
      acc_now[fifo_data] = 1'b1;
    end

    cnt_now = cnt_q;
    if (capture && (cnt_q != CNT_MAX)) begin
      cnt_now = cnt_q + CNT_W'(1);
    end

    bank0_set = capture && (bank_sel_q == BANK_0);
    bank1_set = capture && (bank_sel_q == BANK_1);
    bank0_clr = tick && (bank_sel_q == BANK_1);
    bank1_clr = tick && (bank_sel_q == BANK_0);

    rd_pend_d      = fifo_r_en;
    drop_err_d     = rd_pend_q && !in_range;
    spikes_valid_d = tick;
    bank_sel_d     = bank_sel_q;
    cnt_d          = cnt_now;
    axon_spikes_d  = axon_spikes_q;
    spike_count_d  = spike_count_q;

    if (tick) begin
      axon_spikes_d = acc_now;
      spike_count_d = cnt_now;
      cnt_d         = '0;
      bank_sel_d    = other_bank(bank_sel_q);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q      <= 1'b0;
      bank_sel_q     <= BANK_0;
      cnt_q          <= '0;
      axon_spikes_q  <= '0;
      spike_count_q  <= '0;
      spikes_valid_q <= 1'b0;
      drop_err_q     <= 1'b0;
    end else begin
      rd_pend_q      <= rd_pend_d;
      bank_sel_q     <= bank_sel_d;
      cnt_q          <= cnt_d;
      axon_spikes_q  <= axon_spikes_d;
      spike_count_q  <= spike_count_d;
      spikes_valid_q <= spikes_valid_d;
      drop_err_q     <= drop_err_d;
    end
  end

  axon_bank #(
    .NUM_AXONS (NUM_AXONS),
    .AXON_W    (AXON_W)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .clr     (bank0_clr),
    .set_en  (bank0_set),
    .set_idx (fifo_data),
    .bits    (bank0_bits)
  );

  axon_bank #(
    .NUM_AXONS (NUM_AXONS),
    .AXON_W    (AXON_W)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .clr     (bank1_clr),
    .set_en  (bank1_set),
    .set_idx (fifo_data),
    .bits    (bank1_bits)
  );

  assign axon_spikes  = axon_spikes_q;
  assign spikes_valid = spikes_valid_q;
  assign spike_count  = spike_count_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_axon_spike_decoder.sv
// Directed bench: a behavioural FIFO feeds two decoders (256 and 200 axons)
// and hand-computed bitmaps/counts are compared after each tick.
module tb_axon_spike_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic [7:0]   fifo_data;
  logic         tick;

  logic         r_en_a, r_en_b;
  logic [255:0] spk_a;
  logic [199:0] spk_b;
  logic         val_a, val_b;
  logic [8:0]   cnt_a, cnt_b;
  logic         drop_a, drop_b;

  logic [7:0]   q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           drop_cnt_a = 0;
  int           drop_cnt_b = 0;
  int           val_cnt    = 0;

  logic [255:0] exp_a;
  logic [199:0] exp_b;
  int           snap_a, snap_b, snap_v;

  always #5 clk = ~clk;

  axon_spike_decoder u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_r_en    (r_en_a),
    .tick         (tick),
    .axon_spikes  (spk_a),
    .spikes_valid (val_a),
    .spike_count  (cnt_a),
    .drop_err     (drop_a)
  );

  axon_spike_decoder #(.NUM_AXONS(200)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_r_en    (r_en_b),
    .tick         (tick),
    .axon_spikes  (spk_b),
    .spikes_valid (val_b),
    .spike_count  (cnt_b),
    .drop_err     (drop_b)
  );

  // Synchronous FIFO model: data_out valid the cycle after r_en.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      fifo_empty <= 1'b1;
    end else if (r_en_a) begin
      fifo_data  <= q.pop_front();
      fifo_empty <= (q.size() == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (drop_a) drop_cnt_a++;
    if (drop_b) drop_cnt_b++;
    if (val_a)  val_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] v);
    q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    cycles(3);
    rst = 1'b0;
    check("rst_map",   spk_a, '0);
    check("rst_cnt",   cnt_a, '0);
    check("rst_valid", val_a, '0);
    check("rst_drop",  drop_a, '0);
    check("rst_ren",   r_en_a, '0);

    // Three distinct indices, one of them out of range for the 200-axon decoder.
    snap_b = drop_cnt_b;
    push(8'h03); push(8'h10); push(8'hFF);
    cycles(5);
    snap_v = val_cnt;
    do_tick;
    exp_a = '0; exp_a[3] = 1'b1; exp_a[16] = 1'b1; exp_a[255] = 1'b1;
    exp_b = '0; exp_b[3] = 1'b1; exp_b[16] = 1'b1;
    check("t1_map_a",   spk_a, exp_a);
    check("t1_cnt_a",   cnt_a, 9'd3);
    check("t1_valid",   val_a, 1'b1);
    check("t1_map_b",   spk_b, exp_b);
    check("t1_cnt_b",   cnt_b, 9'd2);
    check("t1_drops_b", drop_cnt_b - snap_b, 1);
    @(negedge clk);
    check("t1_valid_low",  val_a, 1'b0);
    check("t1_valid_once", val_cnt - snap_v, 1);

    // Duplicate index sets one bit but counts twice.
    push(8'h05); push(8'h05);
    cycles(5);
    do_tick;
    exp_a = '0; exp_a[5] = 1'b1;
    exp_b = '0; exp_b[5] = 1'b1;
    check("t2_map_a", spk_a, exp_a);
    check("t2_cnt_a", cnt_a, 9'd2);
    check("t2_map_b", spk_b, exp_b);
    check("t2_cnt_b", cnt_b, 9'd2);

    // Index 200: dropped by the 200-axon decoder, accepted by the 256-axon one.
    snap_a = drop_cnt_a;
    snap_b = drop_cnt_b;
    push(8'hC8);
    @(negedge clk);
    check("t3_drop_early", drop_b, 1'b0);
    @(negedge clk);
    check("t3_drop_pulse", drop_b, 1'b1);
    @(negedge clk);
    check("t3_drop_end",   drop_b, 1'b0);
    cycles(2);
    do_tick;
    exp_a = '0; exp_a[200] = 1'b1;
    check("t3_map_b",    spk_b, '0);
    check("t3_cnt_b",    cnt_b, 9'd0);
    check("t3_drops_b",  drop_cnt_b - snap_b, 1);
    check("t3_map_a",    spk_a, exp_a);
    check("t3_cnt_a",    cnt_a, 9'd1);
    check("t3_drops_a",  drop_cnt_a - snap_a, 0);

    // Tick lands in the same cycle the 0x07 packet is captured.
    push(8'h07); push(8'h08);
    @(negedge clk);
    do_tick;
    exp_a = '0; exp_a[7] = 1'b1;
    exp_b = '0; exp_b[7] = 1'b1;
    check("t4_same_map_a", spk_a, exp_a);
    check("t4_same_cnt_a", cnt_a, 9'd1);
    check("t4_same_map_b", spk_b, exp_b);
    cycles(3);
    do_tick;
    exp_a = '0; exp_a[8] = 1'b1;
    check("t4_next_map_a", spk_a, exp_a);
    check("t4_next_cnt_a", cnt_a, 9'd1);

    // Back-to-back empty ticks must not resurrect stale bits.
    push(8'h11);
    cycles(4);
    do_tick;
    exp_a = '0; exp_a[17] = 1'b1;
    check("t5_map_a", spk_a, exp_a);
    tick = 1'b1;
    @(negedge clk);
    check("t5_tick1_map", spk_a, '0);
    check("t5_tick1_cnt", cnt_a, 9'd0);
    check("t5_tick1_val", val_a, 1'b1);
    @(negedge clk);
    tick = 1'b0;
    check("t5_tick2_map",   spk_a, '0);
    check("t5_tick2_cnt",   cnt_a, 9'd0);
    check("t5_tick2_val",   val_a, 1'b1);
    check("t5_tick2_map_b", spk_b, '0);

    // Reset while 0x2A sits in the read pipeline.
    push(8'h33);
    cycles(4);
    do_tick;
    check("t6_pre_cnt", cnt_a, 9'd1);
    push(8'h2A);
    @(negedge clk);
    rst = 1'b1;
    push(8'h44);
    #1;
    check("t6_ren_gate_a", r_en_a, 1'b0);
    check("t6_ren_gate_b", r_en_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_map",  spk_a, '0);
    check("t6_cnt",  cnt_a, '0);
    check("t6_val",  val_a, '0);
    check("t6_drop", drop_a, '0);
    check("t6_ren",  r_en_a, '0);
    cycles(3);
    do_tick;
    check("t6_tick1_map", spk_a, '0);
    check("t6_tick1_cnt", cnt_a, 9'd0);
    do_tick;
    check("t6_tick2_map", spk_a, '0);
    check("t6_tick2_cnt", cnt_a, 9'd0);

    // 520 packets: counter saturates at 511 on the 256-axon decoder.
    snap_b = drop_cnt_b;
    for (int i = 0; i < 520; i++) begin
      push(i[7:0]);
    end
    cycles(525);
    do_tick;
    check("t7_cnt_a",   cnt_a, 9'd511);
    check("t7_map_a",   spk_a, {256{1'b1}});
    check("t7_cnt_b",   cnt_b, 9'd408);
    check("t7_map_b",   spk_b, {200{1'b1}});
    check("t7_drops_b", drop_cnt_b - snap_b, 112);
    do_tick;
    check("t7_after_cnt", cnt_a, 9'd0);
    check("t7_after_map", spk_a, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
